// File: rtl/prim_fifo_sync_wm.sv
// prim_fifo_sync_wm: synchronous valid/ready FIFO with registered occupancy,
// programmable almost-full/almost-empty watermarks, explicit empty flag and
// sticky overflow/underflow flags.
// Optional feature macro: PRIM_FIFO_DROP_CNT_EN enables a saturating 16-bit
// dropped-write counter on drop_cnt_o; when undefined drop_cnt_o is tied to 0.
module prim_fifo_sync_wm #(
    parameter int unsigned Width             = 16,
    parameter int unsigned Depth             = 8,
    parameter bit          Pass              = 1'b1,
    parameter bit          OutputZeroIfEmpty = 1'b1,
    localparam int unsigned DepthW           = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [Width-1:0]  wdata_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [Width-1:0]  rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [DepthW-1:0] depth_o,
    input  logic [DepthW-1:0] af_thr_i,
    input  logic [DepthW-1:0] ae_thr_i,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              ovf_o,
    output logic              udf_o,
    input  logic              err_clr_i,
    output logic [15:0]       drop_cnt_o
);

    // Pointer value field width; the extra MSB is a wrap flag
    localparam int unsigned PtrVW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned PtrW  = PtrVW + 1;

    // Depth 0/1 is not a meaningful configuration for this primitive
    if (Depth < 2) begin : gen_depth_chk
        $error("prim_fifo_sync_wm: Depth must be >= 2");
    end

    logic                under_rst;
    logic [PtrW-1:0]     wptr;
    logic [PtrW-1:0]     rptr;
    logic [DepthW-1:0]   count;
    logic [Width-1:0]    mem [Depth];

    logic                full_c;
    logic                empty_c;
    logic                pass_c;
    logic                wr_acc_c;
    logic                rd_acc_c;
    logic                wr_store_c;
    logic                rd_store_c;
    logic                ovf_set_c;
    logic                udf_set_c;
    logic [Width-1:0]    rdata_raw_c;

    // Advance a pointer; value field wraps at Depth-1 and toggles the wrap flag
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p[PtrVW-1:0] == PtrVW'(Depth - 1)) begin
            return {~p[PtrW-1], {PtrVW{1'b0}}};
        end
        return {p[PtrW-1], p[PtrVW-1:0] + PtrVW'(1)};
    endfunction

    // Status and handshake decode
    assign full_c  = (wptr[PtrVW-1:0] == rptr[PtrVW-1:0]) && (wptr[PtrW-1] != rptr[PtrW-1]);
    assign empty_c = (count == '0);

    assign wready_o = ~full_c & ~under_rst;
    assign rvalid_o = ~under_rst & (~empty_c | (Pass & wvalid_i));

    // Pass-through consumes the write directly, leaving storage untouched
    assign pass_c     = Pass & empty_c & wvalid_i & rready_i;
    assign wr_acc_c   = wvalid_i & wready_o & ~clr_i;
    assign rd_acc_c   = rvalid_o & rready_i & ~clr_i;
    assign wr_store_c = wr_acc_c & ~pass_c;
    assign rd_store_c = rd_acc_c & ~pass_c;

    assign ovf_set_c = wvalid_i & full_c & ~under_rst;
    assign udf_set_c = rready_i & ~rvalid_o & ~under_rst;

    // Pointer, occupancy and post-reset hold state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            under_rst <= 1'b1;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
        end else begin
            under_rst <= 1'b0;
            if (clr_i) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (wr_store_c) wptr <= ptr_inc(wptr);
                if (rd_store_c) rptr <= ptr_inc(rptr);
                if (wr_store_c && !rd_store_c) begin
                    count <= count + DepthW'(1);
                end else if (rd_store_c && !wr_store_c) begin
                    count <= count - DepthW'(1);
                end
            end
        end
    end

    // Storage array; contents need no reset
    always_ff @(posedge clk_i) begin
        if (wr_store_c) mem[wptr[PtrVW-1:0]] <= wdata_i;
    end

    // Sticky error flags: clr_i dominates, then set, then err_clr_i
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            ovf_o <= 1'b0;
            udf_o <= 1'b0;
        end else begin
            if (ovf_set_c)      ovf_o <= 1'b1;
            else if (err_clr_i) ovf_o <= 1'b0;
            if (udf_set_c)      udf_o <= 1'b1;
            else if (err_clr_i) udf_o <= 1'b0;
        end
    end

    // Read data path with pass-through and optional zeroing
    assign rdata_raw_c = (Pass && empty_c) ? wdata_i : mem[rptr[PtrVW-1:0]];
    assign rdata_o     = (OutputZeroIfEmpty && !rvalid_o) ? '0 : rdata_raw_c;

    // Occupancy and watermark outputs
    assign full_o         = full_c;
    assign empty_o        = empty_c;
    assign depth_o        = count;
    assign almost_full_o  = (count >= af_thr_i);
    assign almost_empty_o = (count <= ae_thr_i);

`ifdef PRIM_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt;
    logic        drop_inc_c;

    assign drop_inc_c = wvalid_i & ~wready_o & ~under_rst;

    // Saturating dropped-write counter; an increment beats err_clr_i
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            drop_cnt <= 16'h0000;
        end else if (drop_inc_c) begin
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end else if (err_clr_i) begin
            drop_cnt <= 16'h0000;
        end
    end

    assign drop_cnt_o = drop_cnt;
`else
    assign drop_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_prim_fifo_sync_wm.sv
// Testbench for prim_fifo_sync_wm (Width=8, Depth=5, Pass=1, OutputZeroIfEmpty=1).
module tb_prim_fifo_sync_wm;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 5;
    localparam int unsigned DW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          wv  = 1'b0;
    logic [W-1:0]  wd  = '0;
    logic          rr  = 1'b0;
    logic          ec  = 1'b0;
    logic [DW-1:0] af  = DW'(3);
    logic [DW-1:0] ae  = DW'(1);

    logic          wready_o, rvalid_o, full_o, empty_o;
    logic          almost_full_o, almost_empty_o, ovf_o, udf_o;
    logic [W-1:0]  rdata_o;
    logic [DW-1:0] depth_o;
    logic [15:0]   drop_cnt_o;

    int errors = 0;
    int checks = 0;

    // Reference model: stored words, post-reset hold, sticky flags, drop count
    logic [W-1:0] mdl_q[$];
    logic [W-1:0] sb_q[$];
    bit           m_ur   = 1'b1;
    bit           m_ovf  = 1'b0;
    bit           m_udf  = 1'b0;
    int           m_drop = 0;
    bit           mon_en = 1'b0;

    prim_fifo_sync_wm #(
        .Width(W),
        .Depth(D),
        .Pass(1'b1),
        .OutputZeroIfEmpty(1'b1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .clr_i(clr),
        .wvalid_i(wv),
        .wready_o(wready_o),
        .wdata_i(wd),
        .rvalid_o(rvalid_o),
        .rready_i(rr),
        .rdata_o(rdata_o),
        .full_o(full_o),
        .empty_o(empty_o),
        .depth_o(depth_o),
        .af_thr_i(af),
        .ae_thr_i(ae),
        .almost_full_o(almost_full_o),
        .almost_empty_o(almost_empty_o),
        .ovf_o(ovf_o),
        .udf_o(udf_o),
        .err_clr_i(ec),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Drive one cycle of stimulus; expected read data enters the scoreboard on acceptance
    task automatic drive(input bit w, input logic [W-1:0] d, input bit r,
                         input bit c, input bit e, input bit s);
        @(posedge clk);
        #1;
        wv = w; wd = d; rr = r; clr = c; ec = e; rst = s;
        if (w && !m_ur && mdl_q.size() < D) sb_q.push_back(d);
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare every output against the model, pop scoreboard on reads, advance model
    always @(negedge clk) begin : mon_blk
        int  n;
        bit  e_full, e_wready, e_rvalid, wacc, racc;
        if (mon_en) begin
            n        = mdl_q.size();
            e_full   = (n == D);
            e_wready = !e_full && !m_ur;
            e_rvalid = !m_ur && (n != 0 || wv);

            chk("wready", wready_o, e_wready);
            chk("rvalid", rvalid_o, e_rvalid);
            chk("full", full_o, e_full);
            chk("empty", empty_o, (n == 0));
            chk("depth", depth_o, n);
            chk("almost_full", almost_full_o, (n >= int'(af)));
            chk("almost_empty", almost_empty_o, (n <= int'(ae)));
            chk("ovf", ovf_o, m_ovf);
            chk("udf", udf_o, m_udf);
`ifdef PRIM_FIFO_DROP_CNT_EN
            chk("drop_cnt", drop_cnt_o, m_drop);
`else
            chk("drop_cnt", drop_cnt_o, 0);
`endif
            if (rvalid_o) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rdata_sb: actual=%0h required=no_valid at %0t", rdata_o, $time);
                end else begin
                    chk("rdata", rdata_o, sb_q[0]);
                    if (rr && !rst && !clr) void'(sb_q.pop_front());
                end
            end else begin
                chk("rdata_zero", rdata_o, 0);
            end

            if (rst) begin
                mdl_q.delete(); sb_q.delete();
                m_ur = 1'b1; m_ovf = 1'b0; m_udf = 1'b0; m_drop = 0;
            end else begin
                if (clr) begin
                    mdl_q.delete(); sb_q.delete();
                    m_ovf = 1'b0; m_udf = 1'b0; m_drop = 0;
                end else begin
                    wacc = wv && e_wready;
                    racc = rr && e_rvalid;
                    if (!(wacc && racc && n == 0)) begin
                        if (racc) void'(mdl_q.pop_front());
                        if (wacc) mdl_q.push_back(wd);
                    end
                    if (wv && e_full && !m_ur) m_ovf = 1'b1;
                    else if (ec)               m_ovf = 1'b0;
                    if (rr && !e_rvalid && !m_ur) m_udf = 1'b1;
                    else if (ec)                  m_udf = 1'b0;
                    if (wv && !e_wready && !m_ur) begin
                        if (m_drop < 65535) m_drop++;
                    end else if (ec) begin
                        m_drop = 0;
                    end
                end
                m_ur = 1'b0;
            end
        end
    end

    initial begin
        int wp;
        // Reset and release
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_depth", depth_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_ae", almost_empty_o, 1);
        idle();
        @(negedge clk);
        chk("rst_hold_wready", wready_o, 0);

        // Fill to full then drain in order
        for (int i = 0; i < D; i++) drive(1'b1, W'(8'h11 * (i + 1)), 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("t1_full", full_o, 1);
        chk("t1_depth", depth_o, D);
        chk("t1_wready", wready_o, 0);
        chk("t1_first", rdata_o, 8'h11);
        for (int i = 0; i < D; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("t1_empty", empty_o, 1);

        // Pass-through on empty
        drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_rvalid", rvalid_o, 1);
        chk("t3_rdata", rdata_o, 8'hA5);
        idle();
        @(negedge clk);
        chk("t3_depth", depth_o, 0);

        // Interleaved writes/reads across several pointer wraps
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 12; i++) drive(1'b1, W'(i * 7), 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();

        // Watermarks while filling and draining
        af = DW'(3); ae = DW'(1);
        for (int k = 1; k <= D; k++) begin
            drive(1'b1, W'(k), 1'b0, 1'b0, 1'b0, 1'b0);
            idle();
            @(negedge clk);
            chk("t4_af_up", almost_full_o, (k >= 3));
            chk("t4_ae_up", almost_empty_o, (k <= 1));
        end
        for (int k = D - 1; k >= 0; k--) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            idle();
            @(negedge clk);
            chk("t4_af_dn", almost_full_o, (k >= 3));
            chk("t4_ae_dn", almost_empty_o, (k <= 1));
        end

        // Overflow, drop count, error clear, underflow
        for (int i = 0; i < D; i++) drive(1'b1, W'(8'h40 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("t5_ovf", ovf_o, 1);
`ifdef PRIM_FIFO_DROP_CNT_EN
        chk("t5_drop", drop_cnt_o, 3);
`else
        chk("t5_drop", drop_cnt_o, 0);
`endif
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        chk("t5_ovf_clr", ovf_o, 0);
        for (int i = 0; i < D; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("t5_udf", udf_o, 1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset pulse with data stored, then clear
        for (int i = 0; i < 3; i++) drive(1'b1, W'(8'h60 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t6_pre_rst_depth", depth_o, 3);
        idle();
        @(negedge clk);
        chk("t6_rst_depth", depth_o, 0);
        chk("t6_rst_rvalid", rvalid_o, 0);
        chk("t6_rst_wready", wready_o, 0);
        idle();
        @(negedge clk);
        chk("t6_wready_back", wready_o, 1);
        for (int i = 0; i < 2; i++) drive(1'b1, W'(8'h70 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("t6_clr_depth", depth_o, 0);
        chk("t6_clr_ovf", ovf_o, 0);
        chk("t6_clr_udf", udf_o, 0);

        // Randomized traffic with varying write pressure and thresholds
        for (int i = 0; i < 3000; i++) begin
            wp = ((i / 200) % 3 == 0) ? 30 : (((i / 200) % 3 == 1) ? 60 : 85);
            if (i % 16 == 0) begin
                af = DW'($urandom_range(0, 7));
                ae = DW'($urandom_range(0, 7));
            end
            drive($urandom_range(0, 99) < wp, W'($urandom), $urandom_range(0, 99) < 50,
                  $urandom_range(0, 63) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 255) == 0);
        end
        idle();
        idle();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prim_fifo_sync_wm.md
Name: prim_fifo_sync_wm

Overview:
Parametrised synchronous FIFO that extends the generic sync FIFO primitive with the following:
- a registered occupancy counter;
- programmable almost-full and almost-empty watermarks;
- an explicit empty flag;
- sticky overflow and underflow error flags.

It is used between SPI shift logic and the register/DMA interface. Watermarks drive interrupt and flow-control logic. Valid/ready on both sides.

Parameters:
Width, 16, data bits per entry (>=1)
Depth, 8, number of entries (>=2; Depth=0/1 not supported, elaboration error)
Pass, 1, 1 = write data may pass combinationally through an empty FIFO
OutputZeroIfEmpty, 1, 1 = rdata_o forced to 0 when rvalid_o=0
DepthW (localparam), $clog2(Depth+1), width of occupancy/threshold buses

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous active-high reset
clr_i  input  1  synchronous flush: pointers/count to 0, storage content don't-care
wvalid_i  input  1  write request
wready_o  output  1  write accepted when wvalid_i & wready_o
wdata_i  input  Width  write data
rvalid_o  output  1  read data valid
rready_i  input  1  read accept
rdata_o  output  Width  read data
full_o  output  1  count == Depth
empty_o  output  1  count == 0 (storage only, ignores pass-through)
depth_o  output  DepthW  registered occupancy
af_thr_i  input  DepthW  almost-full threshold
ae_thr_i  input  DepthW  almost-empty threshold
almost_full_o  output  1  depth_o >= af_thr_i
almost_empty_o  output  1  depth_o <= ae_thr_i
ovf_o  output  1  sticky: write attempted while full
udf_o  output  1  sticky: rready_i asserted while rvalid_o=0
err_clr_i  input  1  clears ovf_o/udf_o
drop_cnt_o  output  16  dropped-write counter (see Optional Feature)

Behaviour:
- Reset (rst_i=1 at edge): wptr=rptr=count=0, ovf=udf=0, drop_cnt=0, under_rst=1.
- under_rst clears on the first edge with rst_i=0. While under_rst=1:
  - wready_o=0, rvalid_o=0;
  - no pointer movement;
  - error flags do not set.
- Reset outputs: wready_o=0, rvalid_o=0, full_o=0, empty_o=1, depth_o=0, almost_empty_o=(0<=ae_thr_i)=1, almost_full_o=(af_thr_i==0), ovf_o=udf_o=0.
- wready_o = ~full & ~under_rst. Accept = wvalid_i & wready_o.
- rvalid_o = ~under_rst & (count!=0 | (Pass & wvalid_i)).
- Pointers are PTRV_W+1 bits; the low field wraps Depth-1 -> 0 and toggles the MSB (non-power-of-2 Depth supported).
- Write latency: data is readable from storage the cycle after accept; depth_o updates the same edge.
- Pass-through (Pass=1, count==0, wvalid_i, rready_i): rdata_o=wdata_i, and the write is consumed directly. Storage, pointers and count are unchanged.
- Pass-through with rready_i=0: the word is stored normally. rvalid_o is still 1 that cycle.
- Count update per edge: +1 on write-only, -1 on read-only, unchanged on both or neither. A simultaneous read+write at count==Depth is read-only, since wready_o=0.
- Watermark outputs are combinational from registered depth_o and the live thresholds; thresholds may change at any time.
- ovf_o sets on wvalid_i & full & ~under_rst. udf_o sets on rready_i & ~rvalid_o & ~under_rst.
- Error flags clear on err_clr_i or clr_i. A set condition in the same cycle as err_clr_i wins; clr_i wins over everything.
- clr_i: next cycle count=0 and empty_o=1. Handshakes in the clr_i cycle are discarded; no error flags set by them.
- rdata_o = storage[rptr] (or wdata_i on pass). It is zeroed when ~rvalid_o and OutputZeroIfEmpty=1.

Optional Feature:
PRIM_FIFO_DROP_CNT_EN
- Defined: drop_cnt_o is a 16-bit counter.
  - Increments each cycle with wvalid_i & ~wready_o & ~under_rst.
  - Saturates at 16'hFFFF.
  - Cleared by rst_i, clr_i or err_clr_i; increment wins over err_clr_i.
- Undefined: drop_cnt_o tied to 0 and no counter flops.

Test Plan:
1. Width=8, Depth=4: reset, then write 0x11,0x22,0x33,0x44 with rready_i=0 -> full_o=1, depth_o=4, wready_o=0; then read -> 0x11,0x22,0x33,0x44 in order, empty_o=1.
2. Depth=5 (non-power-of-2): 12 writes interleaved with reads, keeping depth 1-3 -> order preserved across two pointer wraps, depth_o never exceeds 5.
3. Pass=1, empty: wvalid_i=rready_i=1, wdata_i=0xA5 -> rvalid_o=1 and rdata_o=0xA5 in the same cycle; depth_o stays 0.
4. af_thr_i=3, ae_thr_i=1: fill 0->4 -> almost_empty_o=1 at depth 0-1; almost_full_o rises on the edge depth becomes 3; drain reverses both.
5. At full, assert wvalid_i for 3 cycles -> ovf_o=1 after the first; drop_cnt_o=3 (macro defined) or 0 (undefined). err_clr_i -> ovf_o=0. rready_i on empty -> udf_o=1.
6. rst_i pulsed with depth_o=3 -> next cycle depth_o=0, rvalid_o=0, wready_o=0; wready_o=1 one cycle after rst_i drops. clr_i at depth_o=2 -> depth_o=0, error flags 0.
